// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencer: owns the fetch PC, drives the imem request handshake,
// applies EX-stage redirects, and traps misaligned control-transfer targets.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        flush,
    output logic        misaligned_fault,
    output logic [31:0] fault_addr,
    output logic [31:0] redirect_count
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INSN_B = 4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_pending;
    logic              r_pend_mis;
    logic [XLEN-1:0]   r_if_pc;
    logic              r_if_valid;
    logic              r_fault;
    logic [XLEN-1:0]   r_fault_addr;
    logic [XLEN-1:0]   r_redirect_count;

    logic              w_accept;
    logic              w_redirect;
    logic              w_mis;

    assign w_accept   = imem_req & imem_ready;
    assign w_redirect = ex_valid & (ex_jump | (ex_branch & ex_take_branch));
    assign w_mis      = (ex_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // Next-state: an unaccepted redirect waits in DRAIN so the request stays stable
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_redirect) begin
                    if (!w_accept)  w_state_nxt = S_DRAIN;
                    else if (w_mis) w_state_nxt = S_HALT;
                end
            end
            S_DRAIN: begin
                if (w_accept) w_state_nxt = r_pend_mis ? S_HALT : S_RUN;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Combinational handshake and flush outputs
    always_comb begin
        imem_req = 1'b0;
        flush    = 1'b0;
        case (r_state)
            S_RUN: begin
                imem_req = 1'b1;
                flush    = w_redirect;
            end
            S_DRAIN: imem_req = 1'b1;
            default: begin
                imem_req = 1'b0;
                flush    = 1'b0;
            end
        endcase
    end

    // PC, IF/ID slot, fault capture and redirect counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_pending        <= '0;
            r_pend_mis       <= 1'b0;
            r_if_pc          <= '0;
            r_if_valid       <= 1'b0;
            r_fault          <= 1'b0;
            r_fault_addr     <= '0;
            r_redirect_count <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_redirect) begin
                        r_redirect_count <= XLEN'(r_redirect_count + XLEN'(1));
                        r_if_valid       <= 1'b0;
                        if (w_accept && !w_mis) begin
                            r_pc <= ex_target;
                        end else if (w_accept) begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= ex_target;
                        end else begin
                            r_pending  <= ex_target;
                            r_pend_mis <= w_mis;
                        end
                    end else if (w_accept && !stall) begin
                        r_pc       <= XLEN'(r_pc + XLEN'(INSN_B));
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                    end else if (!w_accept && !stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The response for the old PC is wrong-path; drop it
                    r_if_valid <= 1'b0;
                    if (w_accept) begin
                        if (r_pend_mis) begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= r_pending;
                        end else begin
                            r_pc <= r_pending;
                        end
                    end
                end
                default: r_if_valid <= 1'b0;
            endcase
        end
    end

    assign imem_addr        = r_pc;
    assign if_pc            = r_if_pc;
    assign if_valid         = r_if_valid;
    assign misaligned_fault = r_fault;
    assign fault_addr       = r_fault_addr;
    assign redirect_count   = r_redirect_count;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed scoreboard bench for fetch_redirect_unit: stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_fetch_redirect_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, ex_branch, ex_jump, ex_take_branch;
    logic [31:0] ex_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        flush;
    logic        misaligned_fault;
    logic [31:0] fault_addr;
    logic [31:0] redirect_count;

    fetch_redirect_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_jump          (ex_jump),
        .ex_take_branch   (ex_take_branch),
        .ex_target        (ex_target),
        .stall            (stall),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .if_pc            (if_pc),
        .if_valid         (if_valid),
        .flush            (flush),
        .misaligned_fault (misaligned_fault),
        .fault_addr       (fault_addr),
        .redirect_count   (redirect_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        fl;
        logic        vld;
        logic [31:0] ifpc;
        logic        flt;
        logic [31:0] faddr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    function automatic exp_t mk(input logic req, input logic [31:0] addr, input logic fl,
                                input logic vld, input logic [31:0] ifpc, input logic flt,
                                input logic [31:0] faddr, input logic [31:0] cnt);
        exp_t e;
        e.req = req; e.addr = addr; e.fl = fl; e.vld = vld;
        e.ifpc = ifpc; e.flt = flt; e.faddr = faddr; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s entry=%0d got=%h expected=%h", nm, n_cyc, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_req",         32'(imem_req),         32'(e.req));
            chk("imem_addr",        imem_addr,             e.addr);
            chk("flush",            32'(flush),            32'(e.fl));
            chk("if_valid",         32'(if_valid),         32'(e.vld));
            chk("if_pc",            if_pc,                 e.ifpc);
            chk("misaligned_fault", 32'(misaligned_fault), 32'(e.flt));
            chk("fault_addr",       fault_addr,            e.faddr);
            chk("redirect_count",   redirect_count,        e.cnt);
            n_cyc++;
        end
    end

    task automatic drive(input logic v, input logic b, input logic j, input logic t,
                         input logic [31:0] tgt, input logic rdy, input logic st);
        ex_valid = v; ex_branch = b; ex_jump = j; ex_take_branch = t;
        ex_target = tgt; imem_ready = rdy; stall = st;
    endtask

    task automatic cyc(input logic v, input logic b, input logic j, input logic t,
                       input logic [31:0] tgt, input logic rdy, input logic st, input exp_t e);
        drive(v, b, j, t, tgt, rdy, st);
        q.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic idle(input exp_t e);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, e);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Sequential fetch from reset
        idle(mk(1, 32'h0040_0000, 0, 0, 32'h0,         0, 0, 0));
        idle(mk(1, 32'h0040_0004, 0, 1, 32'h0040_0000, 0, 0, 0));
        idle(mk(1, 32'h0040_0008, 0, 1, 32'h0040_0004, 0, 0, 0));
        // Taken branch accepted immediately
        cyc(1, 1, 0, 1, 32'h0040_0100, 1, 0, mk(1, 32'h0040_000C, 1, 1, 32'h0040_0008, 0, 0, 0));
        idle(mk(1, 32'h0040_0100, 0, 0, 32'h0040_0008, 0, 0, 1));
        idle(mk(1, 32'h0040_0104, 0, 1, 32'h0040_0100, 0, 0, 1));
        // Jump while memory not ready -> DRAIN, later ex inputs ignored
        cyc(1, 0, 1, 0, 32'h0040_0200, 0, 0, mk(1, 32'h0040_0108, 1, 1, 32'h0040_0104, 0, 0, 1));
        cyc(1, 0, 1, 0, 32'h0040_0300, 0, 0, mk(1, 32'h0040_0108, 0, 0, 32'h0040_0104, 0, 0, 2));
        cyc(1, 1, 0, 1, 32'h0040_0400, 0, 0, mk(1, 32'h0040_0108, 0, 0, 32'h0040_0104, 0, 0, 2));
        cyc(1, 0, 1, 0, 32'h0040_0500, 1, 0, mk(1, 32'h0040_0108, 0, 0, 32'h0040_0104, 0, 0, 2));
        idle(mk(1, 32'h0040_0200, 0, 0, 32'h0040_0104, 0, 0, 2));
        // Not-taken branch, then two stalled cycles
        cyc(1, 1, 0, 0, 32'h0040_0800, 1, 0, mk(1, 32'h0040_0204, 0, 1, 32'h0040_0200, 0, 0, 2));
        cyc(0, 0, 0, 0, 32'h0,         1, 1, mk(1, 32'h0040_0208, 0, 1, 32'h0040_0204, 0, 0, 2));
        cyc(0, 0, 0, 0, 32'h0,         1, 1, mk(1, 32'h0040_0208, 0, 1, 32'h0040_0204, 0, 0, 2));
        idle(mk(1, 32'h0040_0208, 0, 1, 32'h0040_0204, 0, 0, 2));
        // Misaligned jump accepted -> HALT
        cyc(1, 0, 1, 0, 32'h0040_0102, 1, 0, mk(1, 32'h0040_020C, 1, 1, 32'h0040_0208, 0, 0, 2));
        idle(mk(0, 32'h0040_020C, 0, 0, 32'h0040_0208, 1, 32'h0040_0102, 3));
        cyc(1, 0, 1, 0, 32'h0040_0300, 1, 0, mk(0, 32'h0040_020C, 0, 0, 32'h0040_0208, 1, 32'h0040_0102, 3));
        idle(mk(0, 32'h0040_020C, 0, 0, 32'h0040_0208, 1, 32'h0040_0102, 3));

        // Reset out of HALT; misaligned branch through DRAIN
        do_reset();
        cyc(1, 1, 0, 1, 32'h0040_0011, 0, 0, mk(1, 32'h0040_0000, 1, 0, 32'h0, 0, 0, 0));
        idle(mk(1, 32'h0040_0000, 0, 0, 32'h0, 0, 0, 1));
        idle(mk(0, 32'h0040_0000, 0, 0, 32'h0, 1, 32'h0040_0011, 1));

        // Counter wrap via backdoor preload
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        force dut.r_redirect_count = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        release dut.r_redirect_count;
        cyc(1, 1, 0, 1, 32'h0040_0040, 1, 0, mk(1, 32'h0040_0004, 1, 1, 32'h0040_0000, 0, 0, 32'hFFFF_FFFF));
        idle(mk(1, 32'h0040_0040, 0, 0, 32'h0040_0000, 0, 0, 0));
        idle(mk(1, 32'h0040_0044, 0, 1, 32'h0040_0040, 0, 0, 0));

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
